// File: rtl/updn_mod_counter.sv
// Modulo up/down counter with clear, load, terminal count and wrap pulse.
// Latency: counter and wrap update one edge after controls are sampled; tc is combinational.
// Backpressure: none; en gates counting, clr/load override en each cycle.
// Optional feature macro: UPDN_SAT_EN (honours sat to saturate at the range ends).
module updn_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX       = 15,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] max_v   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] reset_v = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] one_v   = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic             sat_mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] counter_nxt;
    logic             wrap_nxt;

`ifdef UPDN_SAT_EN
    assign sat_mode = sat;
`else
    // sat is kept on the port so both builds instantiate identically;
    // this build always wraps.
    logic unused_sat;
    assign unused_sat = sat;
    assign sat_mode   = 1'b0;
`endif

    // Range-end detection, terminal count and clamped load value.
    always_comb begin
        at_max   = (counter == max_v);
        at_zero  = (counter == '0);
        tc       = en & ((up & at_max) | (~up & at_zero));
        // Compare one bit wider so the clamp stays a real comparison even
        // when MAX is the largest WIDTH-bit value.
        load_val = ({1'b0, din} > {1'b0, max_v}) ? max_v : din;
    end

    // Next count by priority: clear, load, count step, hold.
    always_comb begin
        counter_nxt = counter;
        wrap_nxt    = 1'b0;
        if (clr) begin
            counter_nxt = '0;
        end else if (load) begin
            counter_nxt = load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    counter_nxt = counter + one_v;
                end else if (!sat_mode) begin
                    counter_nxt = '0;
                    wrap_nxt    = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    counter_nxt = counter - one_v;
                end else if (!sat_mode) begin
                    counter_nxt = max_v;
                    wrap_nxt    = 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= reset_v;
            wrap    <= 1'b0;
        end else begin
            counter <= counter_nxt;
            wrap    <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_updn_mod_counter.sv
module tb_updn_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] din;
    logic       sat;
    logic [3:0] counter;
    logic       tc;
    logic       wrap;

    int n_tests;
    int n_fail;

    updn_mod_counter #(
        .WIDTH    (4),
        .MAX      (9),
        .RESET_VAL(0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .up     (up),
        .clr    (clr),
        .load   (load),
        .din    (din),
        .sat    (sat),
        .counter(counter),
        .tc     (tc),
        .wrap   (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        en    = 1'b0;
        up    = 1'b1;
        clr   = 1'b0;
        load  = 1'b0;
        din   = 4'd0;
        sat   = 1'b0;

        // Reset state, before any clock edge.
        #2;
        chk("rst_cnt", counter, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_tc", tc, 0);
        @(negedge clk);
        reset = 1'b0;

        // Count up 0..9 then wrap to 0.
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("up_cnt", counter, k % 10);
            chk("up_wrap", wrap, (k == 10) ? 1 : 0);
            chk("up_tc", tc, ((k % 10) == 9) ? 1 : 0);
        end

        // Count down from 0: 9 with wrap, then 8, 7.
        up = 1'b0;
        #1;
        chk("dn_tc_at0", tc, 1);
        step();
        chk("dn_cnt9", counter, 9);
        chk("dn_wrap", wrap, 1);
        chk("dn_tc9", tc, 0);
        step();
        chk("dn_cnt8", counter, 8);
        chk("dn_wrap8", wrap, 0);
        step();
        chk("dn_cnt7", counter, 7);

        // Enable low for 4 edges while toggling up: hold at 7.
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            up = ~up;
            step();
            chk("hold_cnt", counter, 7);
            chk("hold_tc", tc, 0);
            chk("hold_wrap", wrap, 0);
        end

        // Load above MAX clamps; clr beats load; load beats en.
        load = 1'b1;
        din  = 4'd13;
        step();
        chk("load_clamp", counter, 9);
        chk("load_wrap", wrap, 0);
        clr = 1'b1;
        din = 4'd5;
        step();
        chk("clr_over_load", counter, 0);
        clr = 1'b0;
        en  = 1'b1;
        up  = 1'b1;
        din = 4'd4;
        step();
        chk("load_over_en", counter, 4);

        // Saturation at the top, then at the bottom.
        din = 4'd9;
        en  = 1'b0;
        step();
        chk("load9", counter, 9);
        load = 1'b0;
        sat  = 1'b1;
        en   = 1'b1;
        up   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
`ifdef UPDN_SAT_EN
            chk("sat_up_cnt", counter, 9);
            chk("sat_up_wrap", wrap, 0);
`else
            chk("nosat_up_cnt", counter, k);
            chk("nosat_up_wrap", wrap, (k == 0) ? 1 : 0);
`endif
        end
        clr = 1'b1;
        step();
        chk("sat_clr", counter, 0);
        clr = 1'b0;
        up  = 1'b0;
        step();
`ifdef UPDN_SAT_EN
        chk("sat_dn_cnt", counter, 0);
        chk("sat_dn_wrap", wrap, 0);
`else
        chk("nosat_dn_cnt", counter, 9);
        chk("nosat_dn_wrap", wrap, 1);
`endif
        sat = 1'b0;

        // Count to 6, reset between edges, release, count from RESET_VAL.
        clr = 1'b1;
        step();
        clr = 1'b0;
        up  = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("pre_rst_cnt", counter, 6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_cnt", counter, 0);
        reset = 1'b0;
        step();
        chk("post_rst_cnt", counter, 1);

        // Reset during a wrap pulse clears it immediately.
        load = 1'b1;
        din  = 4'd9;
        step();
        load = 1'b0;
        step();
        chk("wrap_pulse_cnt", counter, 0);
        chk("wrap_pulse", wrap, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_clears_wrap", wrap, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
